rf2p_port_arbiter: RTL and testbench

//   Shares one two-port register file (port A read, port B write) among NREQ requesters.

---
 rtl/rf2p_port_arbiter.sv | 120 ++++++++++++
 tb/tb_rf2p_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf2p_port_arbiter.sv
// Round-robin arbiter sharing one two-port register file (A read / B write) among NREQ requesters.
// A read that hits the address written in the same cycle is stalled so the write lands first.
module rf2p_port_arbiter #(
  parameter int NREQ = 4,
  parameter int DWD  = 16,
  parameter int AWD  = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_rreq,
  input  logic [NREQ*AWD-1:0]  i_raddr,
  output logic [NREQ-1:0]      o_rgnt,
  output logic [NREQ-1:0]      o_rvalid,
  output logic [DWD-1:0]       o_rdata,
  input  logic [NREQ-1:0]      i_wreq,
  input  logic [NREQ*AWD-1:0]  i_waddr,
  input  logic [NREQ*DWD-1:0]  i_wdata,
  output logic [NREQ-1:0]      o_wgnt,
  output logic                 o_rf_read,
  output logic [AWD-1:0]       o_rf_raddr,
  output logic                 o_rf_write,
  output logic [AWD-1:0]       o_rf_waddr,
  output logic [DWD-1:0]       o_rf_wdata,
  input  logic [DWD-1:0]       i_rf_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [AWD-1:0] raddr_arr [NREQ];
  logic [AWD-1:0] waddr_arr [NREQ];
  logic [DWD-1:0] wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign raddr_arr[gi] = i_raddr[gi*AWD +: AWD];
      assign waddr_arr[gi] = i_waddr[gi*AWD +: AWD];
      assign wdata_arr[gi] = i_wdata[gi*DWD +: DWD];
    end
  endgenerate

  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic            w_found, r_found;
  logic [PW-1:0]   w_idx, r_idx;
  logic [PW-1:0]   w_scan, r_scan;
  logic            w_en, r_en, collision;

  // First asserted request at or after each pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    r_found = 1'b0;
    w_idx   = '0;
    r_idx   = '0;
    w_scan  = '0;
    r_scan  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_scan = PW'((int'(wptr_q) + i) % NREQ);
      r_scan = PW'((int'(rptr_q) + i) % NREQ);
      if (!w_found && i_wreq[w_scan]) begin
        w_found = 1'b1;
        w_idx   = w_scan;
      end
      if (!r_found && i_rreq[r_scan]) begin
        r_found = 1'b1;
        r_idx   = r_scan;
      end
    end
  end

  // A colliding read candidate blocks the read port; nobody behind it is promoted.
  assign w_en      = w_found & i_rst_n;
  assign collision = w_en & r_found & (raddr_arr[r_idx] == waddr_arr[w_idx]);
  assign r_en      = r_found & i_rst_n & ~collision;

  always_comb begin
    o_wgnt     = '0;
    o_rgnt     = '0;
    o_rf_write = w_en;
    o_rf_read  = r_en;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    o_rf_raddr = '0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (w_en) begin
      o_wgnt[w_idx] = 1'b1;
      o_rf_waddr    = waddr_arr[w_idx];
      o_rf_wdata    = wdata_arr[w_idx];
      wptr_d        = (w_idx == LAST) ? '0 : w_idx + ONE;
    end
    if (r_en) begin
      o_rgnt[r_idx] = 1'b1;
      o_rf_raddr    = raddr_arr[r_idx];
      rptr_d        = (r_idx == LAST) ? '0 : r_idx + ONE;
    end
    rvalid_d = o_rgnt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      rvalid_q <= '0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Gated by reset as well, so a tag registered just before reset never reaches a client.
  assign o_rvalid = rvalid_q & {NREQ{i_rst_n}};
  assign o_rdata  = i_rf_rdata;

endmodule

// File: tb/tb_rf2p_port_arbiter.sv
// Bench for rf2p_port_arbiter: directed scenarios plus random traffic against a
// round-robin reference model with a shadow register file.
module tb_rf2p_port_arbiter;
  localparam int NREQ = 4;
  localparam int DWD  = 16;
  localparam int AWD  = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     i_rreq, i_wreq;
  logic [NREQ*AWD-1:0] i_raddr, i_waddr;
  logic [NREQ*DWD-1:0] i_wdata;
  logic [NREQ-1:0]     o_rgnt, o_rvalid, o_wgnt;
  logic [DWD-1:0]      o_rdata, o_rf_wdata, i_rf_rdata;
  logic                o_rf_read, o_rf_write;
  logic [AWD-1:0]      o_rf_raddr, o_rf_waddr;

  always #5 clk = ~clk;

  rf2p_port_arbiter #(.NREQ(NREQ), .DWD(DWD), .AWD(AWD)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rreq(i_rreq), .i_raddr(i_raddr), .o_rgnt(o_rgnt),
    .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .i_wreq(i_wreq), .i_waddr(i_waddr), .i_wdata(i_wdata), .o_wgnt(o_wgnt),
    .o_rf_read(o_rf_read), .o_rf_raddr(o_rf_raddr),
    .o_rf_write(o_rf_write), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .i_rf_rdata(i_rf_rdata)
  );

  // Register file stand-in: data appears the cycle after the read enable.
  logic [DWD-1:0] rf_mem [2**AWD];
  logic [DWD-1:0] rf_q;
  always @(posedge clk) begin
    if (o_rf_write) rf_mem[o_rf_waddr] <= o_rf_wdata;
    if (o_rf_read)  rf_q <= rf_mem[o_rf_raddr];
  end
  assign i_rf_rdata = rf_q;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_rptr, m_wptr, m_rtag, e_ri, e_wi;
  logic [DWD-1:0] m_rdata;
  logic [DWD-1:0] m_mem [2**AWD];

  function automatic logic [AWD-1:0] raddr_of(int k);
    return i_raddr[k*AWD +: AWD];
  endfunction
  function automatic logic [AWD-1:0] waddr_of(int k);
    return i_waddr[k*AWD +: AWD];
  endfunction
  function automatic logic [DWD-1:0] wdata_of(int k);
    return i_wdata[k*DWD +: DWD];
  endfunction
  function automatic logic [31:0] onehot(int k);
    return (k < 0) ? 32'd0 : (32'd1 << k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_r(input int k, input logic req, input logic [AWD-1:0] a);
    i_rreq[k] = req;
    i_raddr[k*AWD +: AWD] = a;
  endtask
  task automatic set_w(input int k, input logic req, input logic [AWD-1:0] a, input logic [DWD-1:0] d);
    i_wreq[k] = req;
    i_waddr[k*AWD +: AWD] = a;
    i_wdata[k*DWD +: DWD] = d;
  endtask
  task automatic clear_reqs();
    i_rreq = '0; i_wreq = '0; i_raddr = '0; i_waddr = '0; i_wdata = '0;
  endtask
  task automatic all_reqs();
    for (int k = 0; k < NREQ; k++) begin
      set_r(k, 1'b1, AWD'(10 + k));
      set_w(k, 1'b1, AWD'(20 + k), DWD'(16'h0A00 + k));
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [31:0] exp_rv;
    #1;
    e_wi = -1;
    e_ri = -1;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (e_wi < 0 && i_wreq[(m_wptr + i) % NREQ]) e_wi = (m_wptr + i) % NREQ;
        if (e_ri < 0 && i_rreq[(m_rptr + i) % NREQ]) e_ri = (m_rptr + i) % NREQ;
      end
      if (e_wi >= 0 && e_ri >= 0 && raddr_of(e_ri) == waddr_of(e_wi)) e_ri = -1;
    end
    chk("wgnt",     32'(o_wgnt),     onehot(e_wi));
    chk("rf_write", 32'(o_rf_write), 32'(e_wi >= 0));
    chk("rf_waddr", 32'(o_rf_waddr), (e_wi >= 0) ? 32'(waddr_of(e_wi)) : 32'd0);
    chk("rf_wdata", 32'(o_rf_wdata), (e_wi >= 0) ? 32'(wdata_of(e_wi)) : 32'd0);
    chk("rgnt",     32'(o_rgnt),     onehot(e_ri));
    chk("rf_read",  32'(o_rf_read),  32'(e_ri >= 0));
    chk("rf_raddr", 32'(o_rf_raddr), (e_ri >= 0) ? 32'(raddr_of(e_ri)) : 32'd0);
    exp_rv = rst_n ? onehot(m_rtag) : 32'd0;
    chk("rvalid",   32'(o_rvalid),   exp_rv);
    if (exp_rv != 0) chk("rdata", 32'(o_rdata), 32'(m_rdata));
    $display("cyc %0d rst_n=%0b rreq=%b wreq=%b rgnt=%b wgnt=%b rvalid=%b rdata=%h",
             cyc, rst_n, i_rreq, i_wreq, o_rgnt, o_wgnt, o_rvalid, o_rdata);
    @(posedge clk);
    if (!rst_n) begin
      m_rptr = 0;
      m_wptr = 0;
      m_rtag = -1;
    end else begin
      if (e_ri >= 0) begin
        m_rdata = m_mem[raddr_of(e_ri)];
        m_rptr  = (e_ri + 1) % NREQ;
      end
      m_rtag = e_ri;
      if (e_wi >= 0) begin
        m_mem[waddr_of(e_wi)] = wdata_of(e_wi);
        m_wptr = (e_wi + 1) % NREQ;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 2**AWD; a++) begin
      rf_mem[a] = '0;
      m_mem[a]  = '0;
    end
    rf_q = '0; m_rdata = '0; m_rtag = -1; m_rptr = 0; m_wptr = 0;
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);

    // Reset held with everyone requesting, then release.
    all_reqs();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_rgnt", 32'(o_rgnt), 32'd0);
      chk("t1_wgnt", 32'(o_wgnt), 32'd0);
      chk("t1_rw",   32'({o_rf_read, o_rf_write}), 32'd0);
      chk("t1_rvalid", 32'(o_rvalid), 32'd0);
      step();
    end
    rst_n = 1'b1;
    #1;
    chk("t1_rgnt_rel", 32'(o_rgnt), 32'd1);
    chk("t1_wgnt_rel", 32'(o_wgnt), 32'd1);
    step();

    // Read round-robin.
    do_reset(1);
    clear_reqs();
    for (int k = 0; k < NREQ; k++) set_r(k, 1'b1, AWD'(40 + k));
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_rgnt", 32'(o_rgnt), 32'd1 << (i % 4));
      chk("t2_rvalid", 32'(o_rvalid), (i == 0) ? 32'd0 : (32'd1 << ((i - 1) % 4)));
      step();
    end

    // Write fairness and readback.
    do_reset(1);
    clear_reqs();
    set_w(1, 1'b1, AWD'(31), 16'h1111);
    set_w(3, 1'b1, AWD'(33), 16'h3333);
    #1; chk("t3_wgnt0", 32'(o_wgnt), 32'd2); step();
    set_w(1, 1'b1, AWD'(31), 16'h2222);
    #1; chk("t3_wgnt1", 32'(o_wgnt), 32'd8); step();
    set_w(3, 1'b1, AWD'(33), 16'h4444);
    #1; chk("t3_wgnt2", 32'(o_wgnt), 32'd2); step();
    #1; chk("t3_wgnt3", 32'(o_wgnt), 32'd8); step();
    clear_reqs();
    set_r(0, 1'b1, AWD'(31));
    step();
    set_r(0, 1'b1, AWD'(33));
    #1; chk("t3_rdata31", 32'(o_rdata), 32'h2222); step();
    clear_reqs();
    #1; chk("t3_rdata33", 32'(o_rdata), 32'h4444); step();

    // Same-address collision: write goes first, read retries.
    do_reset(1);
    clear_reqs();
    set_w(0, 1'b1, AWD'(5), 16'hBEEF);
    set_r(1, 1'b1, AWD'(5));
    #1;
    chk("t4_wgnt", 32'(o_wgnt), 32'd1);
    chk("t4_rgnt", 32'(o_rgnt), 32'd0);
    chk("t4_rf_read", 32'(o_rf_read), 32'd0);
    step();
    set_w(0, 1'b0, '0, '0);
    #1; chk("t4_rgnt_retry", 32'(o_rgnt), 32'd2); step();
    clear_reqs();
    #1;
    chk("t4_rvalid", 32'(o_rvalid), 32'd2);
    chk("t4_rdata", 32'(o_rdata), 32'hBEEF);
    step();

    // Reset arriving while a read is in flight.
    do_reset(1);
    clear_reqs();
    set_r(2, 1'b1, AWD'(7));
    step();
    clear_reqs();
    rst_n = 1'b0;
    #1; chk("t5_rvalid_rst", 32'(o_rvalid), 32'd0); step();
    rst_n = 1'b1;
    #1; chk("t5_rvalid_after", 32'(o_rvalid), 32'd0); step();
    all_reqs();
    #1;
    chk("t5_rgnt", 32'(o_rgnt), 32'd1);
    chk("t5_wgnt", 32'(o_wgnt), 32'd1);
    step();

    // Lone requester at the top index.
    do_reset(1);
    clear_reqs();
    set_r(3, 1'b1, AWD'(9));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_rgnt", 32'(o_rgnt), 32'd8);
      chk("t6_rvalid", 32'(o_rvalid), (i == 0) ? 32'd0 : 32'd8);
      step();
    end

    // Random traffic; requests held until granted, small address space to force collisions.
    clear_reqs();
    step();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (e_ri == k) i_rreq[k] = 1'b0;
        if (e_wi == k) i_wreq[k] = 1'b0;
        if (!i_rreq[k] && $urandom_range(0, 1) == 1)
          set_r(k, 1'b1, AWD'($urandom_range(0, 7)));
        if (!i_wreq[k] && $urandom_range(0, 1) == 1)
          set_w(k, 1'b1, AWD'($urandom_range(0, 7)), DWD'($urandom));
      end
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
